// File: rtl/playlist_if.sv
// Control/status bundle between the playlist sequencer (slave) and the
// button/song-reader side that drives it (master).
interface playlist_if;
    logic       play_button;
    logic       next_button;
    logic       song_done;
    logic       play;
    logic       reset_player;
    logic [1:0] song;
    logic       busy;

    // No valid/ready: every input is a single-cycle pulse acted on in the cycle it is high,
    // and every output is a registered level (reset_player is a one-cycle level).
    modport master (
        output play_button, next_button, song_done,
        input  play, reset_player, song, busy
    );
    modport slave (
        input  play_button, next_button, song_done,
        output play, reset_player, song, busy
    );
endinterface

// File: rtl/playlist_sequencer.sv
// Play/pause/next sequencer for a small song ROM. Define AUTO_ADVANCE_EN to make the
// end of a song step to the next one after a silent gap instead of pausing.
module playlist_sequencer #(
    parameter int NUM_SONGS  = 4,
    parameter int GAP_CYCLES = 48000
) (
    input  logic                       clk,
    input  logic                       reset,
    playlist_if.slave                  ctl,
    output logic [2:0]                 fsm_state,
    output logic [$clog2(GAP_CYCLES):0] gap_count
);
    localparam int              CW        = $clog2(GAP_CYCLES) + 1;
    localparam logic [1:0]      LAST_SONG = 2'(NUM_SONGS - 1);
    localparam logic [CW-1:0]   GAP_LOAD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        PAUSED  = 3'd1,
        PLAYING = 3'd2,
        NEXT    = 3'd3,
        ADVANCE = 3'd4,
        GAP     = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    song, song_nxt, song_inc;
    logic [CW-1:0] cnt, cnt_nxt;

    assign song_inc = (song == LAST_SONG) ? 2'd0 : song + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            song  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            song  <= song_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        song_nxt  = song;
        cnt_nxt   = '0;
        case (state)
            INIT:    state_nxt = PAUSED;
            PAUSED: begin
                if (ctl.next_button)      state_nxt = NEXT;
                else if (ctl.play_button) state_nxt = PLAYING;
            end
            PLAYING: begin
                if (ctl.next_button)      state_nxt = NEXT;
                else if (ctl.play_button) state_nxt = PAUSED;
                else if (ctl.song_done)   state_nxt = ADVANCE;
            end
            NEXT:    state_nxt = PAUSED;
            ADVANCE: begin
`ifdef AUTO_ADVANCE_EN
                state_nxt = GAP;
                song_nxt  = song_inc;
`else
                state_nxt = PAUSED;
`endif
            end
            GAP: begin
                if (ctl.next_button)      state_nxt = NEXT;
                else if (ctl.play_button) state_nxt = PAUSED;
                else if (cnt == '0)       state_nxt = PLAYING;
            end
            default: state_nxt = INIT;
        endcase

        // NEXT is always left after one cycle, so this only fires on entry.
        if (state_nxt == NEXT) song_nxt = song_inc;

        // Staying in GAP implies cnt != 0, so the decrement cannot wrap.
        if (state_nxt == GAP) cnt_nxt = (state == GAP) ? cnt - 1'b1 : GAP_LOAD;
    end

    assign ctl.play         = (state == PLAYING);
    assign ctl.reset_player = (state == INIT) || (state == NEXT) || (state == ADVANCE);
    assign ctl.busy         = (state == PLAYING) || (state == GAP);
    assign ctl.song         = song;
    assign fsm_state        = state;
    assign gap_count        = cnt;
endmodule

// File: tb/tb_playlist_sequencer.sv
// Bench for playlist_sequencer: directed vector table, corner sequences and random
// button traffic checked against a cycle-level behavioural model.
module tb_playlist_sequencer;
    localparam int N   = 4;
    localparam int GAP = 4;
`ifdef AUTO_ADVANCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] st, st1;
    logic [2:0] gc, gc1;
    int         checks = 0;
    int         errors = 0;

    playlist_if ifc();
    playlist_if ifc1();

    playlist_sequencer #(.NUM_SONGS(N), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .ctl(ifc), .fsm_state(st), .gap_count(gc)
    );
    playlist_sequencer #(.NUM_SONGS(1), .GAP_CYCLES(GAP)) dut1 (
        .clk(clk), .reset(reset), .ctl(ifc1), .fsm_state(st1), .gap_count(gc1)
    );

    assign ifc1.play_button = ifc.play_button;
    assign ifc1.next_button = ifc.next_button;
    assign ifc1.song_done   = ifc.song_done;

    always #5 clk = ~clk;

    // Behavioural model: what the player is doing, not how the FSM encodes it.
    int m_song = 0;
    bit m_run = 0;      // song reader enabled
    bit m_sil = 0;      // in the silent gap between songs
    int m_left = 0;     // silent cycles still to go, counting the current one
    bit m_pulse = 0;    // restart pulse this cycle
    bit m_to_gap = 0;   // restart pulse is followed by a gap

    function automatic void model_step(bit r, bit pb, bit nb, bit sd);
        if (r) begin
            m_pulse = 1; m_to_gap = 0; m_run = 0; m_sil = 0; m_left = 0; m_song = 0;
        end else if (m_pulse) begin
            m_pulse = 0;
            if (m_to_gap) begin
                m_sil = 1; m_left = GAP; m_song = (m_song + 1) % N;
            end
        end else if (m_run) begin
            if (nb) begin
                m_run = 0; m_pulse = 1; m_to_gap = 0; m_song = (m_song + 1) % N;
            end else if (pb) begin
                m_run = 0;
            end else if (sd) begin
                m_run = 0; m_pulse = 1; m_to_gap = AUTO;
            end
        end else if (m_sil) begin
            if (nb) begin
                m_sil = 0; m_left = 0; m_pulse = 1; m_to_gap = 0; m_song = (m_song + 1) % N;
            end else if (pb) begin
                m_sil = 0; m_left = 0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_sil = 0; m_run = 1; end
            end
        end else begin
            if (nb) begin
                m_pulse = 1; m_to_gap = 0; m_song = (m_song + 1) % N;
            end else if (pb) begin
                m_run = 1;
            end
        end
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(bit r, bit pb, bit nb, bit sd);
        @(negedge clk);
        reset = r;
        ifc.play_button = pb;
        ifc.next_button = nb;
        ifc.song_done = sd;
        @(posedge clk);
        model_step(r, pb, nb, sd);
        #1;
        check("play", 32'(ifc.play), 32'(m_run));
        check("reset_player", 32'(ifc.reset_player), 32'(m_pulse));
        check("busy", 32'(ifc.busy), 32'(m_run | m_sil));
        check("song", 32'(ifc.song), 32'(m_song));
        check("gap_count", 32'(gc), m_sil ? 32'(m_left - 1) : 32'd0);
        check("song_n1", 32'(ifc1.song), 32'd0);
    endtask

    typedef struct {
        bit         r, pb, nb, sd;
        bit         play, rp, busy;
        logic [1:0] song;
    } vec_t;

    function automatic vec_t mk(bit r, bit pb, bit nb, bit sd, bit play, bit rp, bit busy,
                                logic [1:0] song);
        vec_t v;
        v.r = r; v.pb = pb; v.nb = nb; v.sd = sd;
        v.play = play; v.rp = rp; v.busy = busy; v.song = song;
        return v;
    endfunction

    vec_t vecs[22];

    initial begin
        ifc.play_button = 1'b0;
        ifc.next_button = 1'b0;
        ifc.song_done = 1'b0;

        //          r  pb nb sd   play rp busy song
        vecs[0]  = mk(1, 0, 0, 0, 0, 1, 0, 2'd0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 1, 0, 2'd0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0);
        vecs[4]  = mk(0, 1, 0, 0, 1, 0, 1, 2'd0);
        vecs[5]  = mk(0, 0, 0, 0, 1, 0, 1, 2'd0);
        vecs[6]  = mk(0, 0, 1, 0, 0, 1, 0, 2'd1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 2'd1);
        vecs[8]  = mk(0, 0, 1, 0, 0, 1, 0, 2'd2);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 2'd2);
        vecs[10] = mk(0, 0, 1, 0, 0, 1, 0, 2'd3);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 2'd3);
        vecs[12] = mk(0, 0, 1, 0, 0, 1, 0, 2'd0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 2'd0);
        vecs[14] = mk(0, 0, 0, 1, 0, 0, 0, 2'd0);
        vecs[15] = mk(0, 1, 0, 0, 1, 0, 1, 2'd0);
        vecs[16] = mk(0, 1, 1, 1, 0, 1, 0, 2'd1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 2'd1);
        vecs[18] = mk(0, 1, 0, 0, 1, 0, 1, 2'd1);
        vecs[19] = mk(0, 1, 0, 0, 0, 0, 0, 2'd1);
        vecs[20] = mk(0, 1, 1, 0, 0, 1, 0, 2'd2);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 2'd2);

        for (int i = 0; i < 22; i++) begin
            cycle(vecs[i].r, vecs[i].pb, vecs[i].nb, vecs[i].sd);
            check("tbl_play", 32'(ifc.play), 32'(vecs[i].play));
            check("tbl_reset_player", 32'(ifc.reset_player), 32'(vecs[i].rp));
            check("tbl_busy", 32'(ifc.busy), 32'(vecs[i].busy));
            check("tbl_song", 32'(ifc.song), 32'(vecs[i].song));
        end

        // End of song 2 while playing.
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        check("advance_reset_player", 32'(ifc.reset_player), 32'd1);
        check("advance_play", 32'(ifc.play), 32'd0);
`ifdef AUTO_ADVANCE_EN
        begin
            int low = 0;
            for (int i = 0; i < GAP; i++) begin
                cycle(0, 0, 0, 0);
                if (ifc.play === 1'b0) low++;
                check("gap_counter_seq", 32'(gc), 32'(GAP - 1 - i));
                check("gap_song", 32'(ifc.song), 32'd3);
            end
            cycle(0, 0, 0, 0);
            check("gap_low_cycles", 32'(low), 32'(GAP));
            check("resume_play", 32'(ifc.play), 32'd1);
            check("resume_song", 32'(ifc.song), 32'd3);
        end
`else
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            check("hold_paused_play", 32'(ifc.play), 32'd0);
            check("hold_paused_song", 32'(ifc.song), 32'd2);
        end
        cycle(0, 1, 0, 0);
        check("restart_play", 32'(ifc.play), 32'd1);
        check("restart_song", 32'(ifc.song), 32'd2);
`endif

        // Reset in the middle of a song.
        cycle(1, 0, 0, 0);
        check("mid_play_reset_rp", 32'(ifc.reset_player), 32'd1);
        check("mid_play_reset_song", 32'(ifc.song), 32'd0);
        check("mid_play_reset_play", 32'(ifc.play), 32'd0);
        cycle(0, 0, 0, 0);
        check("after_reset_rp", 32'(ifc.reset_player), 32'd0);
        check("after_reset_busy", 32'(ifc.busy), 32'd0);

`ifdef AUTO_ADVANCE_EN
        // Reset in the middle of the gap.
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("gap_count_before_reset", 32'(gc), 32'd2);
        cycle(1, 0, 0, 0);
        check("gap_reset_count", 32'(gc), 32'd0);
        check("gap_reset_song", 32'(ifc.song), 32'd0);
        check("gap_reset_rp", 32'(ifc.reset_player), 32'd1);
        check("gap_reset_play", 32'(ifc.play), 32'd0);
        cycle(0, 0, 0, 0);
        check("gap_reset_paused_rp", 32'(ifc.reset_player), 32'd0);
        check("gap_reset_paused_busy", 32'(ifc.busy), 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/playlist_sequencer.md
PLAYLIST_SEQUENCER -- requirements
Module: playlist_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_SONGS, default 4, meaning the number of playable songs (legal range 1..4).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 48000, meaning the silent inter-song gap length in clk cycles (legal range >= 1).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 play_button  input  1  one-cycle pulse that toggles play/pause.
REQ-006 next_button  input  1  one-cycle pulse that selects the next song.
REQ-007 song_done  input  1  one-cycle pulse from the song reader marking the end of the current song.
REQ-008 play  output  1  enables the song reader.
REQ-009 reset_player  output  1  one-cycle restart pulse to the song reader and note player.
REQ-010 song  output  2  current song index; forms ROM address bits [6:5].
REQ-011 busy  output  1  high in states PLAYING and GAP.

Function
REQ-012 The FSM SHALL have exactly these states: INIT, PAUSED, PLAYING, NEXT, ADVANCE, GAP.
REQ-013 Outputs SHALL be Moore outputs from registered state:
- play=1 only in PLAYING.
- reset_player=1 only in INIT, NEXT and ADVANCE.
- busy=1 in PLAYING and GAP.
REQ-014 INIT SHALL unconditionally go to PAUSED after one cycle.
REQ-015 PAUSED SHALL go to PLAYING on play_button, go to NEXT on next_button, and otherwise hold.
REQ-016 PLAYING SHALL go to PAUSED on play_button, go to NEXT on next_button, and go to ADVANCE on song_done.
REQ-017 Simultaneous events SHALL be resolved with priority next_button > play_button > song_done.
REQ-018 Entering NEXT SHALL increment song modulo NUM_SONGS (NUM_SONGS-1 wraps to 0); NEXT SHALL last one cycle and then go to PAUSED.
REQ-019 ADVANCE SHALL last one cycle; its successor and its effect on song are defined in REQ-026/REQ-027.
REQ-020 GAP SHALL load a down-counter with GAP_CYCLES-1 on entry and decrement it every cycle.
- GAP SHALL go to PLAYING in the cycle after the counter reads 0, so play is low for exactly GAP_CYCLES cycles.
- next_button in GAP SHALL go to NEXT.
- play_button in GAP SHALL go to PAUSED and clear the counter.
REQ-021 With NUM_SONGS=1, song SHALL remain 0 in every state.
REQ-022 song_done SHALL be ignored in every state other than PLAYING.
REQ-023 The gap counter SHALL be $clog2(GAP_CYCLES)+1 bits wide and SHALL never underflow.

Reset
REQ-024 While reset is high, the next state SHALL be INIT, song SHALL be 0 and the gap counter SHALL be 0; this applies in every state, including mid-GAP and mid-PLAYING.
REQ-025 In the first cycle after reset deasserts: play=0, reset_player=1, song=0, busy=0; the next cycle is PAUSED with reset_player=0.

Configuration
REQ-026 With macro AUTO_ADVANCE_EN defined: ADVANCE SHALL increment song modulo NUM_SONGS and go to GAP, and playback SHALL resume automatically with the next song.
REQ-027 With AUTO_ADVANCE_EN undefined: ADVANCE SHALL leave song unchanged and go to PAUSED, so the same song restarts from its start on the next play_button; state GAP and its counter SHALL be unreachable and may be removed.

Verification
REQ-028 Reset then play_button at cycle 5 -> play=1 from cycle 6, song=0, reset_player=0, busy=1.
REQ-029 While PAUSED, song=3, NUM_SONGS=4, next_button -> one cycle reset_player=1, then song=0, state PAUSED, play=0.
REQ-030 AUTO_ADVANCE_EN defined, GAP_CYCLES=4, song=1, PLAYING, song_done pulse -> reset_player=1 for 1 cycle, song=2, play=0 for exactly 4 cycles, then play=1.
REQ-031 AUTO_ADVANCE_EN undefined, song=2, PLAYING, song_done pulse -> reset_player=1 for 1 cycle, PAUSED, song=2, play=0 until play_button.
REQ-032 PLAYING with play_button, next_button and song_done in the same cycle -> NEXT taken, song+1, then PAUSED.
REQ-033 Reset asserted during GAP with counter=2 -> INIT next cycle, song=0, counter=0, play=0, then PAUSED.
